// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SDRAM A-side port between the CPU bus (port 0) and the loader/DMA (port 1)
//   Each grant opens a fixed slot of SLOT_CYCLES clocks. Address, write strobe and write data are held
//   stable for the whole slot. Read data is captured on the last slot cycle and returned with a
//   one-cycle done pulse. Tie-break is fixed priority (port 0 wins) unless ARB_ROUND_ROBIN_EN is defined,
//   in which case the port not granted last wins.
//   Ports: clk, reset (sync, active-high);
//          pN_req/pN_we/pN_addr/pN_wdata in, pN_rdata/pN_done out (N = 0, 1);
//          mem_addr/mem_write/mem_wdata out, mem_rdata in (SDRAM A side);
//          busy out (slot in progress).
module mem_port_arbiter #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int SLOT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, SLOT0, SLOT1} state_t;
    localparam logic [3:0] LAST = 4'(SLOT_CYCLES - 1);
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx, p0_rdata_nx, p1_rdata_nx;
    logic write_nx, p0_done_nx, p1_done_nx, pick1, slot_end;
`ifdef ARB_ROUND_ROBIN_EN
    // last == 1 means port 1 was granted last, so port 0 wins the first tie after reset
    logic last, last_nx;
    assign pick1 = p1_req & (~p0_req | ~last);
`else
    assign pick1 = p1_req & ~p0_req;
`endif
    assign slot_end = (state != IDLE) && (cnt == LAST);
    assign busy = state != IDLE;
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        addr_nx     = mem_addr;
        wdata_nx    = mem_wdata;
        write_nx    = mem_write;
        p0_rdata_nx = p0_rdata;
        p1_rdata_nx = p1_rdata;
        p0_done_nx  = 1'b0;
        p1_done_nx  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_nx     = last;
`endif
        if (state == IDLE) begin
            write_nx = 1'b0;
            if (p0_req | p1_req) begin
                state_nx = pick1 ? SLOT1 : SLOT0;
                cnt_nx   = 4'd0;
                addr_nx  = pick1 ? p1_addr : p0_addr;
                wdata_nx = pick1 ? p1_wdata : p0_wdata;
                write_nx = pick1 ? p1_we : p0_we;
`ifdef ARB_ROUND_ROBIN_EN
                last_nx  = pick1;
`endif
            end
        end else if (slot_end) begin
            state_nx    = IDLE;
            cnt_nx      = 4'd0;
            write_nx    = 1'b0;
            p0_done_nx  = state == SLOT0;
            p1_done_nx  = state == SLOT1;
            p0_rdata_nx = (state == SLOT0 && !mem_write) ? mem_rdata : p0_rdata;
            p1_rdata_nx = (state == SLOT1 && !mem_write) ? mem_rdata : p1_rdata;
        end else begin
            cnt_nx = cnt + 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            p0_done   <= 1'b0;
            p1_done   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last      <= 1'b1;
`endif
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mem_write <= write_nx;
            p0_rdata  <= p0_rdata_nx;
            p1_rdata  <= p1_rdata_nx;
            p0_done   <= p0_done_nx;
            p1_done   <= p1_done_nx;
`ifdef ARB_ROUND_ROBIN_EN
            last      <= last_nx;
`endif
        end
    end
endmodule
